// File: rtl/matrix_operand_tx_if.sv
// Operand/result handshake bundle between matrix_operand_tx and its neighbours.
// master: the transmit block (drives elem_ready, bus_*, out_*, busy, timeout).
// slave:  the surrounding environment (element source, multiplier, product consumer).
interface matrix_operand_tx_if #(
  parameter int ELEM_W = 16
);
  localparam int BUS_W = 16 * ELEM_W;

  // operand element input
  logic              elem_valid;
  logic              elem_ready;
  logic [ELEM_W-1:0] elem_data;
  // packed operand word toward the multiplier
  logic              bus_valid;
  logic              bus_ready;
  logic [BUS_W-1:0]  bus_data;
  logic              bus_sel;
  // product word from the multiplier
  logic              res_valid;
  logic [BUS_W-1:0]  res_data;
  // product element stream
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  // status
  logic              busy;
  logic              timeout;

  modport master (
    input  elem_valid, elem_data, bus_ready, res_valid, res_data, out_ready,
    output elem_ready, bus_valid, bus_data, bus_sel,
           out_valid, out_data, out_last, busy, timeout
  );

  modport slave (
    output elem_valid, elem_data, bus_ready, res_valid, res_data, out_ready,
    input  elem_ready, bus_valid, bus_data, bus_sel,
           out_valid, out_data, out_last, busy, timeout
  );
endinterface

// File: rtl/matrix_operand_tx.sv
// Purpose: packs 16 A elements then 16 B elements into bus words (A strictly first),
//          then captures the product word and streams it out one element per handshake.
// Latency: bus word valid the cycle after the 16th element is accepted; first product
//          element valid the cycle after res_valid.
// Backpressure: bus_data/bus_sel held while bus_ready=0; out_data/out_last held while
//          out_ready=0; elem_ready low outside the fill phases.
// Ports: clk, rst_n (async active-low); io = matrix_operand_tx_if.master carrying the
//        element input, operand bus, product input, product stream, busy and timeout.
module matrix_operand_tx #(
  parameter int ELEM_W      = 16,
  parameter int RES_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  matrix_operand_tx_if.master io
);
  localparam int BUS_W   = 16 * ELEM_W;
  localparam int TIMER_W = $clog2(RES_TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RES_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FILL_A   = 3'd0,
    SEND_A   = 3'd1,
    FILL_B   = 3'd2,
    SEND_B   = 3'd3,
    WAIT_RES = 3'd4,
    DRAIN    = 3'd5
  } stateT;

  stateT              state, stateNext;
  logic [3:0]         idx, idxNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic               timeoutQ, timeoutNext;
  logic               elemTake, resTake;
  logic [BUS_W-1:0]   opWord;
  logic [BUS_W-1:0]   resWord;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL_A;
      idx      <= 4'd0;
      timer    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      timer    <= timerNext;
      timeoutQ <= timeoutNext;
    end
  end

  always_comb begin
    stateNext   = state;
    idxNext     = idx;
    timerNext   = timer;
    timeoutNext = 1'b0;
    elemTake    = 1'b0;
    resTake     = 1'b0;
    case (state)
      FILL_A, FILL_B: begin
        if (io.elem_valid) begin
          elemTake = 1'b1;
          if (idx == 4'd15) begin
            idxNext   = 4'd0;
            stateNext = (state == FILL_A) ? SEND_A : SEND_B;
          end else begin
            idxNext = idx + 4'd1;
          end
        end
      end
      SEND_A: begin
        if (io.bus_ready) stateNext = FILL_B;
      end
      SEND_B: begin
        if (io.bus_ready) begin
          stateNext = WAIT_RES;
          timerNext = '0;
        end
      end
      WAIT_RES: begin
        // A product arriving on the last allowed cycle still counts.
        if (io.res_valid) begin
          resTake   = 1'b1;
          stateNext = DRAIN;
          idxNext   = 4'd0;
        end else if (timer == TIMER_LAST) begin
          timeoutNext = 1'b1;
          stateNext   = FILL_A;
          idxNext     = 4'd0;
          timerNext   = '0;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      DRAIN: begin
        if (io.out_ready) begin
          if (idx == 4'd15) begin
            idxNext   = 4'd0;
            stateNext = FILL_A;
          end else begin
            idxNext = idx + 4'd1;
          end
        end
      end
      default: begin
        stateNext = FILL_A;
        idxNext   = 4'd0;
      end
    endcase
  end

  // Single operand buffer: B overwrites A's slots, which is safe only because
  // FILL_B is entered after the A word has left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opWord  <= '0;
      resWord <= '0;
    end else begin
      if (elemTake) opWord[idx*ELEM_W +: ELEM_W] <= io.elem_data;
      if (resTake)  resWord <= io.res_data;
    end
  end

  assign io.elem_ready = (state == FILL_A) || (state == FILL_B);
  assign io.bus_valid  = (state == SEND_A) || (state == SEND_B);
  assign io.bus_sel    = (state == SEND_B);
  assign io.bus_data   = opWord;
  assign io.out_valid  = (state == DRAIN);
  assign io.out_data   = (state == DRAIN) ? resWord[idx*ELEM_W +: ELEM_W] : '0;
  assign io.out_last   = (state == DRAIN) && (idx == 4'd15);
  assign io.busy       = !((state == FILL_A) && (idx == 4'd0));
  assign io.timeout    = timeoutQ;
endmodule
